// File: rtl/ioctl_loader_pkg.sv
// Shared definitions for the ioctl download loader.
//   loader_state_t : top-level sequencing states
//   ROM_INDEX      : ioctl_index value that carries the game ROM image
//   DIP_INDEX_DEF  : default ioctl_index value that carries DIP switch bytes
//   CNT_W          : width of the saturating ROM byte counter
package loader_pkg;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    LOADING = 2'd1,
    HOLD    = 2'd2,
    RUN     = 2'd3
  } loader_state_t;

  localparam logic [7:0] ROM_INDEX     = 8'd0;
  localparam logic [7:0] DIP_INDEX_DEF = 8'd254;
  localparam int         CNT_W         = 18;

endpackage

// File: rtl/ioctl_loader_edge_det.sv
// Registered rise/fall detector.
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset, clears the history register
//   sig_i  : level to watch
//   rise_o : sig_i high now, low last cycle
//   fall_o : sig_i low now, high last cycle
// Because the history clears to 0, a level already high when reset
// deasserts shows up as a rise on the first cycle.
module edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic sig_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;
  assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/ioctl_loader.sv
// Glue between the hps_io ioctl download stream and the game core.
// Routes index-0 ROM bytes to the core write port, latches DIP bytes into
// an 8-byte switch bank, checks the ROM byte count and sequences core reset.
//   clk_sys        : system clock
//   reset          : asynchronous active-high reset
//   ioctl_download : download in progress
//   ioctl_index    : download target index
//   ioctl_wr       : one-cycle byte strobe
//   ioctl_addr     : byte address
//   ioctl_dout     : byte data
//   user_reset     : user reset request (menu or button)
//   dl_addr/dl_data/dl_wr : ROM write port to the core (latency 1)
//   dip_sw         : DIP bank, byte n in bits [8n+7:8n]
//   core_reset     : registered reset to the game core
//   rom_loaded     : a valid ROM image is present
//   rom_error      : last ROM download had a bad count or overflowed
module ioctl_loader
  import loader_pkg::*;
#(
  parameter int          DL_AW       = 17,
  parameter logic [16:0] ROM_BYTES   = 17'h1C000,
  parameter int          HOLD_CYCLES = 64,
  parameter logic [7:0]  DIP_INDEX   = DIP_INDEX_DEF
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             ioctl_download,
  input  logic [7:0]       ioctl_index,
  input  logic             ioctl_wr,
  input  logic [24:0]      ioctl_addr,
  input  logic [7:0]       ioctl_dout,
  input  logic             user_reset,
  output logic [DL_AW-1:0] dl_addr,
  output logic [7:0]       dl_data,
  output logic             dl_wr,
  output logic [63:0]      dip_sw,
  output logic             core_reset,
  output logic             rom_loaded,
  output logic             rom_error
);

  localparam logic [CNT_W-1:0] CNT_FULL = {1'b0, ROM_BYTES};
  localparam logic [7:0]       HOLD_M1  = 8'(HOLD_CYCLES - 1);

  loader_state_t    state_q;
  logic [CNT_W-1:0] cnt_q, cnt_base, cnt_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       hold_q;
  logic             dl_wr_q;
  logic [DL_AW-1:0] dl_addr_q;
  logic [7:0]       dl_data_q;
  logic [63:0]      dip_q;
  logic             core_reset_q, loaded_q, error_q;

  logic rom_sel, dip_sel, in_range, rom_wr, ovf_wr;
  logic sel_rise, sel_fall;

  assign rom_sel  = ioctl_download & (ioctl_index == ROM_INDEX);
  assign dip_sel  = ioctl_wr & (ioctl_index == DIP_INDEX) & (ioctl_addr[24:3] == '0);
  assign in_range = ioctl_addr < {8'd0, ROM_BYTES};
  assign rom_wr   = ioctl_wr & rom_sel & in_range;
  assign ovf_wr   = ioctl_wr & rom_sel & ~in_range;

  edge_det u_sel_edge (
    .clk_i  (clk_sys),
    .rst_i  (reset),
    .sig_i  (rom_sel),
    .rise_o (sel_rise),
    .fall_o (sel_fall)
  );

  // A rise always means LOADING entry; clear the count and overflow first so
  // a write arriving on the entry cycle is still counted.
  always_comb begin
    cnt_base = sel_rise ? '0 : cnt_q;
    cnt_d    = cnt_base;
    if (rom_wr && (cnt_base != '1)) begin
      cnt_d = cnt_base + 1'b1;
    end
    ovf_d = (sel_rise ? 1'b0 : ovf_q) | ovf_wr;
  end

  // ROM write port and DIP bank
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dl_wr_q   <= 1'b0;
      dl_addr_q <= '0;
      dl_data_q <= '0;
      dip_q     <= '0;
    end else begin
      dl_wr_q <= rom_wr;
      if (rom_wr) begin
        dl_addr_q <= ioctl_addr[DL_AW-1:0];
        dl_data_q <= ioctl_dout;
      end
      if (dip_sel) begin
        dip_q[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
      end
    end
  end

  // Load sequencing
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= BOOT;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      hold_q       <= '0;
      loaded_q     <= 1'b0;
      error_q      <= 1'b0;
      core_reset_q <= 1'b1;
    end else begin
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      core_reset_q <= (state_q != RUN) | user_reset;
      // rom_sel is already high throughout LOADING, so a rise can only come
      // from BOOT, HOLD or RUN; it beats HOLD expiry.
      if (sel_rise) begin
        state_q  <= LOADING;
        loaded_q <= 1'b0;
        error_q  <= 1'b0;
      end else begin
        case (state_q)
          LOADING: begin
            if (sel_fall) begin
              if ((cnt_q == CNT_FULL) && !ovf_q) begin
                state_q <= HOLD;
                hold_q  <= HOLD_M1;
              end else begin
                state_q <= BOOT;
                error_q <= 1'b1;
              end
            end
          end
          HOLD: begin
            if (hold_q == '0) begin
              state_q  <= RUN;
              loaded_q <= 1'b1;
            end else begin
              hold_q <= hold_q - 8'd1;
            end
          end
          BOOT, RUN: ;
          default: state_q <= BOOT;
        endcase
      end
    end
  end

  assign dl_wr      = dl_wr_q;
  assign dl_addr    = dl_addr_q;
  assign dl_data    = dl_data_q;
  assign dip_sw     = dip_q;
  assign core_reset = core_reset_q;
  assign rom_loaded = loaded_q;
  assign rom_error  = error_q;

endmodule
